// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch control directly upstream of the
// instruction memory. Each instruction runs FETCH -> DECODE -> EXECUTE(xN) ->
// UPDATE. The next PC is sequential, an absolute jump, jump-if-zero, or a halt.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   start               level; leaves IDLE (and chains instructions) when high
//   stall               holds DECODE/EXECUTE (ignored in IDLE/FETCH/UPDATE)
//   opcode, jump, jiz   decoded fields returned by instruction memory
//   zero_flag           ALU zero, sampled in EXECUTE's final cycle
//   address             fetch address (PC)
//   im_select           one-cycle fetch strobe per instruction
//   exec_en             high in every EXECUTE cycle
//   busy / halted       activity / HALT status
//   retired_count       (FETCH_RETIRE_COUNT_EN only) UPDATE cycles, mod 2^16
//
// Optional feature macro: FETCH_RETIRE_COUNT_EN
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          EXEC_CYCLES = 2,
  parameter logic [3:0]  OP_JMP      = 4'b1110,
  parameter logic [3:0]  OP_JIZ      = 4'b1111,
  parameter logic [3:0]  OP_HALT     = 4'b1101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic [3:0]  opcode,
  input  logic [11:0] jump,
  input  logic [7:0]  jiz,
  input  logic        zero_flag,
  output logic [15:0] address,
  output logic        im_select,
  output logic        exec_en,
  output logic        busy,
  output logic        halted
`ifdef FETCH_RETIRE_COUNT_EN
  ,
  output logic [15:0] retired_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_pc, w_pc_next;
  logic [3:0]  r_op;
  logic [11:0] r_jump;
  logic [7:0]  r_jiz;
  logic [3:0]  r_cnt;
  logic        r_im_select, r_exec_en, r_busy, r_halted;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: if (!stall) w_next = S_EXEC;
      S_EXEC:   if (!stall && r_cnt == 4'd0) w_next = S_UPDATE;
      S_UPDATE: begin
        if (r_op == OP_HALT) w_next = S_HALT;
        else if (start)      w_next = S_FETCH;
        else                 w_next = S_IDLE;
      end
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Next PC uses the live zero_flag: it is evaluated on the edge that leaves
  // EXECUTE, i.e. exactly EXECUTE's final cycle.
  always_comb begin
    w_pc_next = r_pc + 16'd1;
    if (r_op == OP_JMP)                   w_pc_next = {4'b0, r_jump};
    else if (r_op == OP_JIZ && zero_flag) w_pc_next = {8'b0, r_jiz};
    else if (r_op == OP_HALT)             w_pc_next = r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_op        <= 4'd0;
      r_jump      <= 12'd0;
      r_jiz       <= 8'd0;
      r_cnt       <= 4'd0;
      r_im_select <= 1'b0;
      r_exec_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state <= w_next;
      // PC is written on entry to UPDATE so the new address is already stable
      // in the cycle before the following FETCH.
      if (r_state == S_EXEC && w_next == S_UPDATE) r_pc <= w_pc_next;
      if (r_state == S_DECODE && !stall) begin
        r_op   <= opcode;
        r_jump <= jump;
        r_jiz  <= jiz;
        r_cnt  <= 4'(EXEC_CYCLES - 1);
      end else if (r_state == S_EXEC && !stall && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Outputs are registered copies of the next-state decode, so they line
      // up with r_state.
      r_im_select <= (w_next == S_FETCH);
      r_exec_en   <= (w_next == S_EXEC);
      r_busy      <= (w_next != S_IDLE) && (w_next != S_HALT);
      r_halted    <= (w_next == S_HALT);
    end
  end

  assign address   = r_pc;
  assign im_select = r_im_select;
  assign exec_en   = r_exec_en;
  assign busy      = r_busy;
  assign halted    = r_halted;

`ifdef FETCH_RETIRE_COUNT_EN
  logic [15:0] r_retired;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_retired <= 16'd0;
    else if (r_state == S_UPDATE) r_retired <= r_retired + 16'd1;
  end
  assign retired_count = r_retired;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. A second instance with RESET_PC=16'hFFFF
// exercises the 16-bit PC wrap.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, start2, stall, zero_flag;
  logic [3:0]  opcode;
  logic [11:0] jump;
  logic [7:0]  jiz;
  logic [15:0] address, address2;
  logic        im_select, exec_en, busy, halted;
  logic        im_select2, exec_en2, busy2, halted2;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [15:0] retired_count, retired_count2;
`endif

  int checks = 0;
  int errors = 0;
  int n_im, n_ex;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .opcode(opcode), .jump(jump), .jiz(jiz), .zero_flag(zero_flag),
    .address(address), .im_select(im_select), .exec_en(exec_en),
    .busy(busy), .halted(halted)
`ifdef FETCH_RETIRE_COUNT_EN
    , .retired_count(retired_count)
`endif
  );

  fetch_sequencer #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stall(stall),
    .opcode(opcode), .jump(jump), .jiz(jiz), .zero_flag(zero_flag),
    .address(address2), .im_select(im_select2), .exec_en(exec_en2),
    .busy(busy2), .halted(halted2)
`ifdef FETCH_RETIRE_COUNT_EN
    , .retired_count(retired_count2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (im_select) n_im++;
    if (exec_en)   n_ex++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    tick();
    while (!im_select && n < 10) begin
      tick();
      n++;
    end
    chk("fetch_seen", im_select, 1);
  endtask

  // From a FETCH sample: run one unstalled instruction (5 cycles) and check
  // the strobe pattern plus the next FETCH address.
  task automatic run_instr(input string tag, input logic [15:0] exp_addr);
    n_im = 0;
    n_ex = 0;
    ticks(5);
    chk({tag, "_im_at_fetch"}, im_select, 1);
    chk({tag, "_im_count"}, n_im, 1);
    chk({tag, "_exec_count"}, n_ex, 2);
    chk({tag, "_addr"}, address, exp_addr);
  endtask

  initial begin
    rst_n = 0; start = 0; start2 = 0; stall = 0; zero_flag = 0;
    opcode = 4'b0010; jump = 12'h0; jiz = 8'h0;
    ticks(2);
    chk("rst_addr", address, 16'h0000);
    chk("rst_im", im_select, 0);
    chk("rst_exec", exec_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr2", address2, 16'hFFFF);
`ifdef FETCH_RETIRE_COUNT_EN
    chk("rst_retired", retired_count, 0);
`endif
    rst_n = 1;
    tick();
    chk("idle_busy", busy, 0);

    // Sequential program: 0,1,2,3
    start = 1;
    wait_fetch();
    chk("first_fetch_addr", address, 16'h0000);
    chk("first_fetch_busy", busy, 1);
    run_instr("seq1", 16'h0001);
    run_instr("seq2", 16'h0002);
    run_instr("seq3", 16'h0003);

    // Branches
    opcode = 4'b1110; jump = 12'h0A5;
    run_instr("jmp", 16'h00A5);
    opcode = 4'b1111; jiz = 8'h07; zero_flag = 1;
    run_instr("jiz_taken", 16'h0007);
    zero_flag = 0;
    run_instr("jiz_not_taken", 16'h0008);

    // Stall 3 cycles in DECODE and 2 cycles mid-EXECUTE
    opcode = 4'b0010;
    n_im = 0; n_ex = 0;
    tick();
    stall = 1; ticks(3);
    stall = 0; tick();
    chk("stall_exec_en", exec_en, 1);
    stall = 1; ticks(2);
    stall = 0; ticks(3);
    chk("stall_im_count", n_im, 1);
    chk("stall_exec_count", n_ex, 4);
    chk("stall_addr", address, 16'h0009);

    // Jump to 5, then HALT there
    opcode = 4'b1110; jump = 12'h005;
    run_instr("jmp5", 16'h0005);
    opcode = 4'b1101;
    n_im = 0;
    ticks(5);
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_addr", address, 16'h0005);
    n_im = 0; n_ex = 0;
    ticks(10);
    chk("halt_no_im", n_im, 0);
    chk("halt_no_exec", n_ex, 0);
    chk("halt_hold_addr", address, 16'h0005);
    chk("halt_stays", halted, 1);

    // Reset releases HALT immediately
    rst_n = 0; start = 0;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_addr", address, 16'h0000);
    chk("halt_rst_busy", busy, 0);
    #2 rst_n = 1;

    // PC wrap on the second instance
    opcode = 4'b0010;
    start2 = 1;
    tick();
    chk("wrap_fetch_im", im_select2, 1);
    chk("wrap_fetch_addr", address2, 16'hFFFF);
    start2 = 1;
    ticks(5);
    chk("wrap_next_im", im_select2, 1);
    chk("wrap_next_addr", address2, 16'h0000);
    start2 = 0;

    // Reset mid-EXECUTE abandons the instruction
    start = 1;
    wait_fetch();
    run_instr("pre_rst", 16'h0001);
    ticks(2);
    chk("mid_exec_en", exec_en, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_addr", address, 16'h0000);
    chk("mid_rst_exec", exec_en, 0);
    chk("mid_rst_im", im_select, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_halted", halted, 0);
    #2 rst_n = 1;

`ifdef FETCH_RETIRE_COUNT_EN
    // Four instructions then HALT: five retirements
    opcode = 4'b0010;
    wait_fetch();
    run_instr("rc1", 16'h0001);
    run_instr("rc2", 16'h0002);
    run_instr("rc3", 16'h0003);
    run_instr("rc4", 16'h0004);
    opcode = 4'b1101;
    ticks(5);
    chk("rc_halted", halted, 1);
    chk("rc_count", retired_count, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
